// File: rtl/otfc_pkg.sv
// Shared types for the on-the-fly quotient converter: FSM states and the
// (plus, minus) signed-digit encodings.
package otfc_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [1:0] DIG_POS    = 2'b10;
  localparam logic [1:0] DIG_NEG    = 2'b01;
  localparam logic [1:0] DIG_ZERO_A = 2'b00;
  localparam logic [1:0] DIG_ZERO_B = 2'b11;
endpackage

// File: rtl/otfc_quotient_converter_if.sv
// Digit-stream input and result handshake of the quotient converter.
interface otfc_quotient_converter_if #(parameter int DIGITS = 8);
  localparam int W = DIGITS + 1;

  logic         start;
  logic         d_plus;
  logic         d_minus;
  logic         d_valid;
  logic         d_ready;
  logic [W-1:0] result;
  logic         result_valid;
  logic         result_ready;
  logic         busy;

  modport master (
    output start, d_plus, d_minus, d_valid, result_ready,
    input  d_ready, result, result_valid, busy
  );

  modport slave (
    input  start, d_plus, d_minus, d_valid, result_ready,
    output d_ready, result, result_valid, busy
  );
endinterface

// File: rtl/otfc_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q / QM pair
// (QM tracks Q-1) using only shifts and selects.
module otfc_step
  import otfc_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic         d_plus,
  input  logic         d_minus,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case ({d_plus, d_minus})
      DIG_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      DIG_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: ;  // both zero encodings keep the defaults above
    endcase
  end
endmodule

// File: rtl/otfc_quotient_converter.sv
// Serial signed-digit quotient to two's-complement converter with a
// valid/ready result port; no carry-propagate adder anywhere in the path.
module otfc_quotient_converter
  import otfc_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input logic clk,
  input logic rst_n,
  otfc_quotient_converter_if.slave cv
);
  localparam int W  = DIGITS + 1;
  localparam int CW = $clog2(DIGITS + 1);

  state_e        state, state_nx;
  logic [W-1:0]  q, qm, q_nx, qm_nx, res;
  logic [CW-1:0] cnt;
  logic          acc, last;

  assign acc  = (state == CONVERT) && cv.d_valid;
  assign last = (cnt == CW'(DIGITS - 1));

  otfc_step #(.W(W)) u_step (
    .q       (q),
    .qm      (qm),
    .d_plus  (cv.d_plus),
    .d_minus (cv.d_minus),
    .q_next  (q_nx),
    .qm_next (qm_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cv.start)        state_nx = CONVERT;
      CONVERT: if (acc && last)     state_nx = DONE;
      DONE:    if (cv.result_ready) state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // The result register only loads on the final digit, so partial
  // conversions are never visible on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      qm  <= '1;
      cnt <= '0;
      res <= '0;
    end else if (state == IDLE && cv.start) begin
      q   <= '0;
      qm  <= '1;
      cnt <= '0;
    end else if (acc) begin
      q   <= q_nx;
      qm  <= qm_nx;
      cnt <= cnt + 1'b1;
      if (last) res <= q_nx;
    end
  end

  assign cv.d_ready      = (state == CONVERT);
  assign cv.result_valid = (state == DONE);
  assign cv.busy         = (state != IDLE);
  assign cv.result       = res;
endmodule

// File: tb/tb_otfc_quotient_converter.sv
// Bench for the quotient converter: directed table on DIGITS=4 plus random
// digit streams on DIGITS = 2, 4, 8, 16 checked against an integer model.
module tb_otfc_quotient_converter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, d_plus = 1'b0, d_minus = 1'b0, d_valid = 1'b0, result_ready = 1'b0;
  int   sel = 0;

  logic [3:0] rv, drdy, bsy;
  int         res [4];
  int         qv  [4];
  int         qmv [4];
  int         cntv[4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance k has DIGITS = 2**(k+1); only the selected one sees start.
  for (genvar k = 0; k < 4; k++) begin : g
    localparam int D = 2 ** (k + 1);
    localparam int W = D + 1;
    otfc_quotient_converter_if #(.DIGITS(D)) ifc ();
    otfc_quotient_converter #(.DIGITS(D)) u (.clk(clk), .rst_n(rst_n), .cv(ifc.slave));
    assign ifc.start        = start && (sel == k);
    assign ifc.d_plus       = d_plus;
    assign ifc.d_minus      = d_minus;
    assign ifc.d_valid      = d_valid;
    assign ifc.result_ready = result_ready;
    assign rv[k]   = ifc.result_valid;
    assign drdy[k] = ifc.d_ready;
    assign bsy[k]  = ifc.busy;
    assign res[k]  = {{(32-W){ifc.result[W-1]}}, ifc.result};
    assign qv[k]   = {{(32-W){u.q[W-1]}}, u.q};
    assign qmv[k]  = {{(32-W){u.qm[W-1]}}, u.qm};
    assign cntv[k] = 32'(u.cnt);
  end

  logic [1:0] dq[16];

  typedef struct {
    logic [7:0] pairs;  // four (plus,minus) pairs, first digit in [7:6]
    int         gap;
    int         hold;
    int         exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int ref_sum(input int nd);
    int s = 0;
    for (int i = 0; i < nd; i++)
      s += (int'(dq[i][1]) - int'(dq[i][0])) * (1 << (nd - 1 - i));
    return s;
  endfunction

  // Full conversion on instance k with digits dq[0..nd-1].
  task automatic run_conv(input int k, input int nd, input int gmin, input int gmax,
                          input int hmin, input int hmax, input int exp);
    int v = 0;
    int gap, hold;
    sel = k; d_valid = 1'b0; result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(bsy[k]), 1);
    chk("d_ready_convert", int'(drdy[k]), 1);
    for (int i = 0; i < nd; i++) begin
      gap = (i == 0) ? 0 : $urandom_range(gmax, gmin);
      for (int j = 0; j < gap; j++) begin
        d_valid = 1'b0;
        start = 1'($urandom_range(1, 0));
        d_plus = 1'($urandom_range(1, 0));
        tick();
        chk("cnt_frozen", cntv[k], i);
        chk("q_frozen", qv[k], v);
      end
      start = 1'b0;
      d_valid = 1'b1;
      d_plus = dq[i][1];
      d_minus = dq[i][0];
      tick();
      d_valid = 1'b0;
      v = 2 * v + (int'(dq[i][1]) - int'(dq[i][0]));
      chk("q_partial", qv[k], v);
      chk("qm_is_q_minus_1", qmv[k], qv[k] - 1);
      chk("result_valid_timing", int'(rv[k]), (i == nd - 1) ? 1 : 0);
    end
    chk("result", res[k], exp);
    chk("d_ready_done", int'(drdy[k]), 0);
    hold = $urandom_range(hmax, hmin);
    for (int j = 0; j < hold; j++) begin
      start = 1'($urandom_range(1, 0));
      d_valid = 1'($urandom_range(1, 0));
      tick();
      chk("hold_valid", int'(rv[k]), 1);
      chk("hold_result", res[k], exp);
      chk("hold_q", qv[k], exp);
    end
    start = 1'b1; result_ready = 1'b1; d_valid = 1'b0;
    tick();
    start = 1'b0; result_ready = 1'b0; d_valid = 1'b1;
    chk("valid_falls", int'(rv[k]), 0);
    chk("idle_not_busy", int'(bsy[k]), 0);
    tick();
    d_valid = 1'b0;
    chk("start_with_ready_ignored", int'(bsy[k]), 0);
    chk("idle_result_kept", res[k], exp);
    chk("idle_dvalid_ignored", qv[k], exp);
  endtask

  initial begin
    vec_t tbl[4];
    int   r, nd;
    tbl[0] = '{8'b10_00_01_10, 0, 0, 7};
    tbl[1] = '{8'b01_01_01_01, 0, 1, -15};
    tbl[2] = '{8'b11_00_10_11, 1, 0, 2};
    tbl[3] = '{8'b10_10_10_10, 3, 5, 15};

    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      chk("reset_valid", int'(rv[k]), 0);
      chk("reset_d_ready", int'(drdy[k]), 0);
      chk("reset_busy", int'(bsy[k]), 0);
      chk("reset_result", res[k], 0);
      chk("reset_qm", qmv[k], -1);
    end
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 4; i++) dq[i] = tbl[t].pairs[7-2*i -: 2];
      run_conv(1, 4, tbl[t].gap, tbl[t].gap, tbl[t].hold, tbl[t].hold, tbl[t].exp);
    end

    // Reset in the middle of a conversion.
    sel = 1; start = 1'b1;
    tick();
    start = 1'b0; d_valid = 1'b1; d_plus = 1'b1; d_minus = 1'b0;
    repeat (2) tick();
    d_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(rv[1]), 0);
    chk("abort_d_ready", int'(drdy[1]), 0);
    chk("abort_busy", int'(bsy[1]), 0);
    chk("abort_q", qv[1], 0);
    tick();
    rst_n = 1'b1;
    tick();
    dq[0] = 2'b00; dq[1] = 2'b00; dq[2] = 2'b00; dq[3] = 2'b01;
    run_conv(1, 4, 0, 0, 0, 0, -1);

    // Random regression on every width.
    for (int k = 0; k < 4; k++) begin
      nd = 2 ** (k + 1);
      for (int n = 0; n < 20; n++) begin
        for (int i = 0; i < nd; i++) begin
          r = $urandom_range(3, 0);
          dq[i] = r[1:0];
        end
        if (n == 0) for (int i = 0; i < nd; i++) dq[i] = 2'b10;
        if (n == 1) for (int i = 0; i < nd; i++) dq[i] = 2'b01;
        run_conv(k, nd, 0, 3, 0, 2, ref_sum(nd));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/otfc_quotient_converter.md
Name: otfc_quotient_converter

Overview:
Downstream stage of the online divider's borrow-save adder and digit-selection path. Consumes the quotient as a serial stream of radix-2 signed digits, MSB first, each encoded as a (plus, minus) bit pair. Performs on-the-fly conversion into a two's-complement integer without a final carry-propagate addition, and presents the result through a valid/ready handshake.

Parameters:
DIGITS, 8, number of signed quotient digits per conversion (>=2)
W, DIGITS+1, result width in bits (derived, not overridable)
CW, $clog2(DIGITS+1), digit-counter width (derived)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin new conversion; honoured only in IDLE
d_plus  input  1  positive component of current digit
d_minus  input  1  negative component; digit value = d_plus - d_minus
d_valid  input  1  digit pair valid this cycle
d_ready  output  1  converter accepts a digit this cycle
result  output  W  two's-complement value sum(q_i * 2^(DIGITS-1-i)), i=0 is the first digit
result_valid  output  1  result stable and valid
result_ready  input  1  consumer takes result
busy  output  1  high in CONVERT or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Q=0; QM=all ones (-1); cnt=0; d_ready=0; result_valid=0; busy=0; result=0. All outputs are registered or decoded from state, with no combinational path from inputs to outputs.
- Digit decode: (0,0) and (1,1) map to 0; (1,0) maps to +1; (0,1) maps to -1. The (1,1) case is legal and must not be flagged.
- Update rules, applied on each accepted digit (d_valid & d_ready), with shifts truncated to W bits:
  - q=+1: Q<={Q,1}, QM<={Q,0}
  - q=0: Q<={Q,0}, QM<={QM,1}
  - q=-1: Q<={QM,1}, QM<={QM,0}
- Invariant after every accepted digit: QM == Q - 1.
- States:
  - IDLE: d_ready=0. When start=1, Q<=0, QM<=all ones, cnt<=0, and the next state is CONVERT.
  - CONVERT: d_ready=1, and busy=1. Each accepted digit increments cnt. The digit accepted while cnt==DIGITS-1 moves the state to DONE on the same edge. d_valid=0 stalls with no state change, and gaps of any length are legal.
  - DONE: result=Q, held stable; result_valid=1; d_ready=0. When result_ready=1, the next state is IDLE and result_valid falls the following cycle. result keeps its value in IDLE until the next start.
- Latency: result_valid rises the cycle after the last digit is accepted. Minimum occupancy from the start cycle is DIGITS+2 cycles.
- Boundary and simultaneous-event rules:
  - start in CONVERT or DONE is ignored.
  - start and result_ready together in DONE: complete the handshake only. The new conversion needs start in IDLE.
  - d_valid in IDLE or DONE is ignored, with no state change.
  - Range: the all-ones digit stream gives +(2^DIGITS - 1) and the all-minus stream gives -(2^DIGITS - 1). Both fit W bits, so overflow is impossible.
  - Reset asserted mid-conversion aborts immediately to IDLE. No partial result is exposed.

Decomposition:
- Package otfc_pkg holds:
  - the state enum (IDLE, CONVERT, DONE), 2 bits;
  - digit-encoding localparams: DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO_A=2'b00, DIG_ZERO_B=2'b11.
- One combinational sub-module, otfc_step, is natural. It takes Q, QM, d_plus and d_minus and produces Q_next and QM_next, so the update rule can be unit-tested separately.
- The top level holds the FSM, counter and registers.

Test Plan:
- DIGITS=4. Stream +1,0,-1,+1 with d_valid continuous -> result=5'b00111 (7). result_valid rises the cycle after the 4th accept.
- DIGITS=4. Stream -1,-1,-1,-1 -> result=5'b10001 (-15). Check intermediate Q after each accept: 11111, 11101, 11001, 10001.
- DIGITS=4. Stream (1,1),(0,0),(1,0),(1,1) -> result=5'b00010 (2). Confirms both zero encodings are legal.
- DIGITS=4. Stream +1,+1,+1,+1 with d_valid low for 3 cycles between each digit -> result=15, and cnt frozen during gaps. Then hold result_ready=0 for 5 cycles -> result stays 15 and result_valid stays 1. Then start pulses in DONE are ignored.
- Assert rst_n=0 after 2 of 4 digits -> next cycle state=IDLE, result_valid=0, d_ready=0. After release, start plus stream 0,0,0,-1 -> result=5'b11111 (-1).
- Random regression over DIGITS∈{2,4,8,16}: random digit streams with random d_valid gaps -> result equals the integer reference sum, and QM==Q-1 holds after every accept.
